// File: rtl/udp_tx_builder.sv
`default_nettype none
// udp_tx_builder: emits Ethernet II / IPv4 / UDP frames on a 32-bit AXI-Stream.
// Header and IPv4 checksum come from the latched command; payload is read from PBM and shifted by 16 bits.
module udp_tx_builder #(
  parameter int         DATA_WIDTH  = 32,
  parameter int         MAX_PAYLOAD = 1472,
  parameter logic [7:0] IP_TTL      = 8'h40
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_cmd_valid,
  output logic                    o_cmd_ready,
  input  logic [15:0]             i_cmd_len,
  input  logic [47:0]             i_dst_mac,
  input  logic [31:0]             i_dst_ip,
  input  logic [15:0]             i_dst_port,
  input  logic [47:0]             i_src_mac,
  input  logic [31:0]             i_src_ip,
  input  logic [15:0]             i_src_port,
  input  logic [DATA_WIDTH-1:0]   i_pbm_rdata,
  input  logic                    i_pbm_rvalid,
  output logic                    o_pbm_rready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  output logic                    o_frame_done,
  output logic                    o_cmd_err
);

  typedef enum logic [2:0] {IDLE, CSUM, FOLD, HDR, BODY} state_t;
  state_t state, state_nxt;

  logic [15:0] len, tot_bytes, frame_len, ip_id, csum, hold;
  logic [47:0] dst_mac, src_mac;
  logic [31:0] dst_ip, src_ip;
  logic [15:0] dst_port, src_port;
  logic [19:0] sum;
  logic [2:0]  csum_cnt;
  logic [10:0] word_idx;
  logic        out_valid, out_last, err;
  logic [31:0] out_data;
  logic [3:0]  out_keep;

  logic        oversize;
  logic [15:0] cmd_tot, cmd_frame;
  logic [15:0] ip_len, udp_len, len_p40, pos;
  logic [15:0] hw_a, hw_b;
  logic [16:0] fold1;
  logic [15:0] fold2;
  logic        emitting, need, slot, load, frame_done, is_last;
  logic [31:0] word_nxt;
  logic [3:0]  keep_nxt;

  assign oversize  = i_cmd_len > 16'(MAX_PAYLOAD);
  assign cmd_tot   = i_cmd_len + 16'd42;
  assign cmd_frame = (cmd_tot < 16'd60) ? 16'd60 : cmd_tot;

  assign ip_len  = len + 16'd28;
  assign udp_len = len + 16'd8;
  assign len_p40 = len + 16'd40;
  assign pos     = {3'b000, word_idx, 2'b00};

  assign fold1 = {1'b0, sum[15:0]} + {13'd0, sum[19:16]};
  assign fold2 = fold1[15:0] + {15'd0, fold1[16]};

  // Two checksum halfwords per CSUM cycle; the checksum field itself counts as zero.
  always_comb begin
    hw_a = 16'h0000;
    hw_b = 16'h0000;
    case (csum_cnt)
      3'd0: begin hw_a = 16'h4500;          hw_b = ip_len;        end
      3'd1: begin hw_a = ip_id;             hw_b = 16'h4000;      end
      3'd2: begin hw_a = {IP_TTL, 8'h11};   hw_b = src_ip[31:16]; end
      3'd3: begin hw_a = src_ip[15:0];      hw_b = dst_ip[31:16]; end
      3'd4: begin hw_a = dst_ip[15:0];      hw_b = 16'h0000;      end
      default: ;
    endcase
  end

  // A fresh PBM word is needed while payload byte 4*(word_idx-10) is still inside L.
  always_comb begin
    emitting = (state == HDR || state == BODY) && (pos < frame_len);
    need     = (word_idx >= 11'd10) && (pos < len_p40);
    slot     = !out_valid || m_axis_tready;
    load     = emitting && slot && (!need || i_pbm_rvalid);
    is_last  = (pos + 16'd4) >= frame_len;

    word_nxt = 32'h0;
    case (word_idx)
      11'd0: word_nxt = dst_mac[47:16];
      11'd1: word_nxt = {dst_mac[15:0], src_mac[47:32]};
      11'd2: word_nxt = src_mac[31:0];
      11'd3: word_nxt = 32'h0800_4500;
      11'd4: word_nxt = {ip_len, ip_id};
      11'd5: word_nxt = {16'h4000, IP_TTL, 8'h11};
      11'd6: word_nxt = {csum, src_ip[31:16]};
      11'd7: word_nxt = {src_ip[15:0], dst_ip[31:16]};
      11'd8: word_nxt = {dst_ip[15:0], src_port};
      11'd9: word_nxt = {dst_port, udp_len};
      default: word_nxt = {(word_idx == 11'd10) ? 16'h0000 : hold,
                           need ? i_pbm_rdata[31:16] : 16'h0000};
    endcase
    // Zero everything past the real frame end: PBM tail bytes and padding.
    for (int b = 0; b < 4; b++) begin
      if ((pos + 16'(b)) >= tot_bytes) word_nxt[31-8*b -: 8] = 8'h00;
    end

    keep_nxt = 4'hF;
    if (is_last) begin
      case (frame_len[1:0])
        2'd1:    keep_nxt = 4'h8;
        2'd2:    keep_nxt = 4'hC;
        2'd3:    keep_nxt = 4'hE;
        default: keep_nxt = 4'hF;
      endcase
    end
  end

  assign frame_done = out_valid && m_axis_tready && out_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    o_cmd_ready  = 1'b0;
    o_pbm_rready = emitting && need && slot;
    case (state)
      IDLE: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid && !oversize) state_nxt = CSUM;
      end
      CSUM:    if (csum_cnt == 3'd4) state_nxt = FOLD;
      FOLD:    state_nxt = HDR;
      HDR:     if (load && word_idx == 11'd9) state_nxt = BODY;
      BODY:    if (frame_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len       <= '0; tot_bytes <= '0; frame_len <= '0;
      dst_mac   <= '0; src_mac   <= '0; dst_ip    <= '0; src_ip <= '0;
      dst_port  <= '0; src_port  <= '0;
      ip_id     <= '0; sum       <= '0; csum_cnt  <= '0; csum   <= '0;
      word_idx  <= '0; hold      <= '0; err       <= 1'b0;
      out_valid <= 1'b0; out_last <= 1'b0; out_data <= '0; out_keep <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: if (i_cmd_valid) begin
          len       <= i_cmd_len;
          tot_bytes <= cmd_tot;
          frame_len <= cmd_frame;
          dst_mac   <= i_dst_mac;  src_mac  <= i_src_mac;
          dst_ip    <= i_dst_ip;   src_ip   <= i_src_ip;
          dst_port  <= i_dst_port; src_port <= i_src_port;
          sum       <= '0;
          csum_cnt  <= '0;
          err       <= oversize;
        end
        CSUM: begin
          sum      <= sum + {4'd0, hw_a} + {4'd0, hw_b};
          csum_cnt <= csum_cnt + 3'd1;
        end
        FOLD: begin
          csum     <= ~fold2;
          word_idx <= '0;
        end
        default: ;
      endcase

      if (load) begin
        word_idx <= word_idx + 11'd1;
        if (need) hold <= i_pbm_rdata[15:0];
      end

      if (slot) begin
        out_valid <= load;
        if (load) begin
          out_data <= word_nxt;
          out_keep <= keep_nxt;
          out_last <= is_last;
        end
      end

      if (frame_done) ip_id <= ip_id + 16'd1;
    end
  end

  assign m_axis_tdata  = out_data;
  assign m_axis_tkeep  = out_keep;
  assign m_axis_tvalid = out_valid;
  assign m_axis_tlast  = out_last;
  assign o_frame_done  = frame_done;
  assign o_cmd_err     = err;

endmodule
`default_nettype wire

// File: tb/tb_udp_tx_builder.sv
`default_nettype none
`timescale 1ns/1ps
// Randomized bench for udp_tx_builder: byte-level frame model, per-handshake compare, stall stability.
module tb_udp_tx_builder;

  localparam int MAXP = 1472;
  localparam logic [47:0] SRC_MAC  = 48'h02_11_22_33_44_55;
  localparam logic [31:0] SRC_IP   = 32'hC0A8010A;
  localparam logic [15:0] SRC_PORT = 16'd5000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_cmd_valid = 1'b0;
  logic        o_cmd_ready;
  logic [15:0] i_cmd_len = '0;
  logic [47:0] i_dst_mac = '0;
  logic [31:0] i_dst_ip = '0;
  logic [15:0] i_dst_port = '0;
  logic [31:0] i_pbm_rdata = '0;
  logic        i_pbm_rvalid = 1'b0;
  logic        o_pbm_rready;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tvalid, m_axis_tlast;
  logic        m_axis_tready = 1'b1;
  logic        o_frame_done, o_cmd_err;

  always #5 clk = ~clk;

  udp_tx_builder #(.DATA_WIDTH(32), .MAX_PAYLOAD(MAXP), .IP_TTL(8'h40)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_len(i_cmd_len),
    .i_dst_mac(i_dst_mac), .i_dst_ip(i_dst_ip), .i_dst_port(i_dst_port),
    .i_src_mac(SRC_MAC), .i_src_ip(SRC_IP), .i_src_port(SRC_PORT),
    .i_pbm_rdata(i_pbm_rdata), .i_pbm_rvalid(i_pbm_rvalid), .o_pbm_rready(o_pbm_rready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .o_frame_done(o_frame_done), .o_cmd_err(o_cmd_err)
  );

  typedef struct packed { logic [31:0] d; logic [3:0] k; logic l; } word_t;
  word_t       exp_q[$];
  logic [7:0]  pay [0:2047];
  logic [31:0] pbm_mem [0:511];
  logic [31:0] cap [0:511];
  logic [3:0]  cap_k [0:511];
  int          cap_n = 0;
  int          vectors = 0, miscompares = 0;
  int          pbm_rd_cnt = 0, rd_base = 0, done_cnt = 0, err_cnt = 0;
  int          valid_cycles = 0, rready_cycles = 0, last_reads = 0;
  bit          stall_en = 1'b0, prev_stall = 1'b0;
  logic [36:0] prev_word = '0;
  logic [15:0] exp_id = '0, model_csum = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Frame model: lay out the bytes, checksum the IPv4 header with end-around carry, cut into words.
  task automatic build_expect(input int len, input logic [47:0] dmac, input logic [31:0] dip,
                              input logic [15:0] dport, input logic [15:0] id);
    logic [7:0]  fb [0:1599];
    logic [15:0] tl, ul, cs;
    int t, nw, s;
    logic [3:0] k;
    t  = (42 + len < 60) ? 60 : 42 + len;
    nw = (t + 3) / 4;
    tl = 16'(len + 28);
    ul = 16'(len + 8);
    for (int i = 0; i < 1600; i++) fb[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      fb[i]     = dmac[47-8*i -: 8];
      fb[6 + i] = SRC_MAC[47-8*i -: 8];
    end
    fb[12] = 8'h08; fb[13] = 8'h00; fb[14] = 8'h45; fb[15] = 8'h00;
    fb[16] = tl[15:8]; fb[17] = tl[7:0]; fb[18] = id[15:8]; fb[19] = id[7:0];
    fb[20] = 8'h40; fb[21] = 8'h00; fb[22] = 8'h40; fb[23] = 8'h11;
    for (int i = 0; i < 4; i++) begin
      fb[26 + i] = SRC_IP[31-8*i -: 8];
      fb[30 + i] = dip[31-8*i -: 8];
    end
    fb[34] = SRC_PORT[15:8]; fb[35] = SRC_PORT[7:0];
    fb[36] = dport[15:8];    fb[37] = dport[7:0];
    fb[38] = ul[15:8];       fb[39] = ul[7:0];
    for (int j = 0; j < len; j++) fb[42 + j] = pay[j];
    s = 0;
    for (int i = 14; i < 34; i += 2) s += int'({fb[i], fb[i+1]});
    while (s > 65535) s = (s & 65535) + (s >> 16);
    cs = ~(16'(s));
    model_csum = cs;
    fb[24] = cs[15:8]; fb[25] = cs[7:0];
    for (int w = 0; w < nw; w++) begin
      k = 4'hF;
      if (w == nw - 1) k = (t % 4 == 1) ? 4'h8 : (t % 4 == 2) ? 4'hC : (t % 4 == 3) ? 4'hE : 4'hF;
      exp_q.push_back('{d: {fb[4*w], fb[4*w+1], fb[4*w+2], fb[4*w+3]}, k: k, l: (w == nw - 1)});
    end
  endtask

  task automatic monitor_step();
    word_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
      return;
    end
    if (prev_stall)
      chk("stall_hold", {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast}, {1'b1, prev_word});
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_word  = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
    if (m_axis_tvalid) valid_cycles++;
    if (o_pbm_rready) rready_cycles++;
    if (o_pbm_rready && i_pbm_rvalid) pbm_rd_cnt++;
    if (o_cmd_err) err_cnt++;
    if (m_axis_tvalid && m_axis_tready) begin
      cap[cap_n & 511]   = m_axis_tdata;
      cap_k[cap_n & 511] = m_axis_tkeep;
      if (exp_q.size() == 0) begin
        chk("extra_word", {m_axis_tdata, m_axis_tkeep, m_axis_tlast}, 37'h0);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("word%0d", cap_n), {m_axis_tdata, m_axis_tkeep, m_axis_tlast}, {e.d, e.k, e.l});
        chk("frame_done_on_last", o_frame_done, e.l);
      end
      cap_n++;
    end else if (o_frame_done) begin
      chk("frame_done_no_hs", o_frame_done, 1'b0);
    end
    if (o_frame_done) done_cnt++;
  endtask

  task automatic drive_step();
    m_axis_tready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    i_pbm_rvalid  = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    i_pbm_rdata   = pbm_mem[(pbm_rd_cnt - rd_base) & 511];
  endtask

  task automatic run_frame(input int len, input bit stall, input bit pattern,
                           input logic [31:0] dip, input int abort_at, output bit aborted);
    logic [47:0] dmac;
    logic [15:0] dport;
    int n, rd0, d0, nrd;
    aborted = 1'b0;
    dmac  = {16'($urandom), 32'($urandom)};
    dport = 16'($urandom);
    for (int i = 0; i < 2048; i++) pay[i] = pattern ? 8'(i) : 8'($urandom);
    nrd = (len + 3) / 4;
    for (int m = 0; m < 512; m++) pbm_mem[m] = {pay[(4*m) & 2047], pay[(4*m+1) & 2047],
                                                 pay[(4*m+2) & 2047], pay[(4*m+3) & 2047]};
    // Bytes beyond L inside the last PBM word are garbage that must never reach the wire.
    for (int j = len; j < 4 * nrd; j++) pbm_mem[j/4][31-8*(j%4) -: 8] = 8'hA5;
    build_expect(len, dmac, dip, dport, exp_id);
    cap_n    = 0;
    rd_base  = pbm_rd_cnt;
    rd0      = pbm_rd_cnt;
    d0       = done_cnt;
    stall_en = stall;

    n = 0;
    while (!o_cmd_ready && n < 100) begin @(posedge clk); #1; n++; end
    chk("cmd_ready_wait", o_cmd_ready, 1'b1);
    i_cmd_valid = 1'b1; i_cmd_len = 16'(len);
    i_dst_mac = dmac; i_dst_ip = dip; i_dst_port = dport;
    @(posedge clk); #1;
    i_cmd_valid = 1'b0;
    chk("busy_not_ready", o_cmd_ready, 1'b0);
    n = 0;
    while (!m_axis_tvalid && n < 20) begin @(posedge clk); #1; n++; end
    chk("first_valid_latency", n, 7);

    n = 0;
    while ((exp_q.size() != 0 || done_cnt == d0) && n < 20000) begin
      if (abort_at >= 0 && cap_n >= abort_at) begin
        aborted = 1'b1;
        break;
      end
      @(posedge clk); #1; n++;
    end
    stall_en = 1'b0;
    if (!aborted) begin
      chk("frame_complete", n < 20000, 1'b1);
      last_reads = pbm_rd_cnt - rd0;
      chk("pbm_reads", last_reads, nrd);
      chk("frame_done_count", done_cnt - d0, 1);
      chk("ip_id", cap[4][15:0], exp_id);
      exp_id = exp_id + 16'd1;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit ab;
    int v0, r0, e0, rd0, len;
    for (int m = 0; m < 512; m++) pbm_mem[m] = '0;
    fork
      forever begin @(negedge clk); monitor_step(); end
      forever begin @(posedge clk); #1; drive_step(); end
    join_none

    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", o_cmd_ready, 1'b1);
    chk("rst_outputs", {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata, o_pbm_rready,
                        o_frame_done, o_cmd_err}, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reference frame: L=32, counting payload.
    run_frame(32, 1'b0, 1'b1, 32'hC0A80164, -1, ab);
    chk("t1_words", cap_n, 19);
    chk("t1_model_csum", model_csum, 16'hB6F2);
    chk("t1_csum", cap[6][31:16], 16'hB6F2);
    chk("t1_id", cap[4][15:0], 16'h0000);
    chk("t1_word10", cap[10], 32'h0000_0001);
    chk("t1_word11", cap[11], 32'h0203_0405);
    chk("t1_last", {cap[18], cap_k[18]}, {32'h1E1F_0000, 4'hC});
    chk("t1_reads", last_reads, 8);

    run_frame(0, 1'b0, 1'b0, $urandom, -1, ab);
    chk("t2_words", cap_n, 15);
    chk("t2_id", cap[4][15:0], 16'h0001);
    chk("t2_totlen", cap[4][31:16], 16'h001C);
    chk("t2_udplen", cap[9][15:0], 16'h0008);
    for (int w = 10; w < 15; w++) chk($sformatf("t2_zero%0d", w), cap[w], 32'h0);
    chk("t2_keep", cap_k[14], 4'hF);
    chk("t2_reads", last_reads, 0);

    run_frame(19, 1'b0, 1'b0, $urandom, -1, ab);
    chk("t3_words", cap_n, 16);
    chk("t3_keep", cap_k[15], 4'h8);
    chk("t3_reads", last_reads, 5);

    run_frame(1, 1'b0, 1'b0, $urandom, -1, ab);
    chk("t4_words", cap_n, 15);
    chk("t4_keep", cap_k[14], 4'hF);

    // Oversize command is rejected without any stream or PBM activity.
    v0 = valid_cycles; r0 = rready_cycles; e0 = err_cnt; rd0 = pbm_rd_cnt;
    i_cmd_valid = 1'b1; i_cmd_len = 16'd1473;
    @(posedge clk); #1;
    i_cmd_valid = 1'b0;
    chk("err_pulse", o_cmd_err, 1'b1);
    repeat (20) begin @(posedge clk); #1; end
    chk("err_count", err_cnt - e0, 1);
    chk("err_no_valid", valid_cycles - v0, 0);
    chk("err_no_rready", rready_cycles - r0, 0);
    chk("err_no_reads", pbm_rd_cnt - rd0, 0);
    chk("err_ready", o_cmd_ready, 1'b1);

    run_frame(100, 1'b1, 1'b0, $urandom, -1, ab);
    chk("t5_reads", last_reads, 25);
    chk("t5_words", cap_n, 36);

    for (int r = 0; r < 8; r++) begin
      len = $urandom_range(0, 300);
      run_frame(len, 1'($urandom_range(0, 1)), 1'b0, $urandom, -1, ab);
    end
    run_frame(MAXP, 1'b1, 1'b0, $urandom, -1, ab);
    chk("max_words", cap_n, 379);

    // Asynchronous reset while word 12 is on the bus.
    run_frame(64, 1'b0, 1'b0, $urandom, 12, ab);
    chk("abort_reached", ab, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_mid_rready", o_pbm_rready, 1'b0);
    exp_q.delete();
    exp_id = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_ready", o_cmd_ready, 1'b1);
    run_frame(32, 1'b0, 1'b0, $urandom, -1, ab);
    chk("post_rst_id", cap[4][15:0], 16'h0000);
    chk("post_rst_words", cap_n, 19);

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
